apb_slave_mem: RTL and testbench

APB completer that sits directly downstream of the APB requester and consumes its `PSEL`, `PENABLE`, `PWRITE`, `paddr` and `pwdata` outputs. It holds a word-addressed register memory and returns `PREADY`, `prdata` and `PSLVERR`. A programmable wait-state counter stretches every access phase. Out-of-range accesses complete with an error response and leave the memory unchanged.

---
 rtl/apb_slave_mem.sv | 95 +++++++++
 tb/tb_apb_slave_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory. Every access phase is
// stretched by WAIT_CYCLES wait states; out-of-range addresses complete with PSLVERR.
module apb_slave_mem #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [WIDTH:0]   paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic             PREADY,
  output logic [WIDTH-1:0] prdata,
  output logic             PSLVERR
);

  localparam int               IDX_W  = $clog2(DEPTH);
  localparam logic [3:0]       WAIT_C = 4'(WAIT_CYCLES);
  localparam logic [WIDTH-1:0] LIMIT  = WIDTH'(DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             wr_q;
  logic             inrange_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0] idx_d;
  logic             inrange_d;
  logic             ready;
  logic             unused_sel;

  assign idx_d      = paddr[2 +: IDX_W];
  assign inrange_d  = (paddr[WIDTH-1:0] < LIMIT);
  // The top address bit selects this completer upstream and carries no meaning here.
  assign unused_sel = paddr[WIDTH];
  assign ready      = (state_q == ACCESS) && (cnt_q == WAIT_C);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      inrange_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) state_q <= SETUP;
        end
        SETUP: begin
          wr_q      <= PWRITE;
          idx_q     <= idx_d;
          inrange_q <= inrange_d;
          wdata_q   <= pwdata;
          cnt_q     <= '0;
          if (!PSEL)        state_q <= IDLE;
          else if (PENABLE) state_q <= ACCESS;
          else              state_q <= SETUP;
        end
        ACCESS: begin
          if (ready) begin
            // Commit here so a transfer chained straight after sees the new word.
            if (wr_q && inrange_q) mem_q[idx_q] <= wdata_q;
            cnt_q   <= '0;
            state_q <= (PSEL && !PENABLE) ? SETUP : IDLE;
          end else if (!PSEL) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q < WAIT_C) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && !inrange_q;
  assign prdata  = (ready && !wr_q && inrange_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized scoreboard bench for apb_slave_mem: a two-wait-state and a zero-wait
// instance share one bus, each checked against its own array model.
module tb_apb_slave_mem;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int IDXW  = $clog2(DEPTH);
  localparam int WAITA = 2;

  logic             PCLK    = 1'b0;
  logic             PRESETn = 1'b1;
  logic             PSEL    = 1'b0;
  logic             PENABLE = 1'b0;
  logic             PWRITE  = 1'b0;
  logic [WIDTH:0]   paddr   = '0;
  logic [WIDTH-1:0] pwdata  = '0;
  logic             sel_z   = 1'b0;

  logic             psel_a, psel_b, rdy_a, rdy_b, err_a, err_b;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             PREADY, PSLVERR;
  logic [WIDTH-1:0] prdata;

  assign psel_a  = PSEL & ~sel_z;
  assign psel_b  = PSEL & sel_z;
  assign PREADY  = sel_z ? rdy_b : rdy_a;
  assign PSLVERR = sel_z ? err_b : err_a;
  assign prdata  = sel_z ? rd_b  : rd_a;

  apb_slave_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT_CYCLES(WAITA)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .paddr(paddr), .pwdata(pwdata), .PREADY(rdy_a), .prdata(rd_a), .PSLVERR(err_a));

  apb_slave_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .paddr(paddr), .pwdata(pwdata), .PREADY(rdy_b), .prdata(rd_b), .PSLVERR(err_b));

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  exp_t             expq [$];
  exp_t             mon_e;
  logic [WIDTH-1:0] model [2][DEPTH];
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
    expq.delete();
  endtask

  // Reference: word index from bits [5:2], in range below DEPTH*4 bytes.
  task automatic push_exp(input bit w, input logic [WIDTH:0] a, input logic [WIDTH-1:0] d);
    exp_t e;
    bit   inr;
    int   idx;
    int   dv;
    inr    = (a[WIDTH-1:0] < WIDTH'(DEPTH * 4));
    idx    = int'(a[2 +: IDXW]);
    dv     = sel_z ? 1 : 0;
    e.err  = !inr;
    e.data = (!w && inr) ? model[dv][idx] : '0;
    if (w && inr) model[dv][idx] = d;
    expq.push_back(e);
  endtask

  always @(negedge PCLK) begin
    if (PREADY === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_pready", 64'(PREADY), 64'(0));
      end else begin
        mon_e = expq.pop_front();
        check("prdata", 64'(prdata), 64'(mon_e.data));
        check("pslverr", 64'(PSLVERR), 64'(mon_e.err));
      end
    end else begin
      check("idle_outputs", {31'b0, PSLVERR, prdata}, 64'(0));
    end
  end

  task automatic drive_setup(input bit w, input logic [WIDTH:0] a, input logic [WIDTH-1:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; paddr = a; pwdata = d;
  endtask

  // Runs one transfer and returns at posedge+1 of its PREADY cycle.
  task automatic xfer(input bit w, input logic [WIDTH:0] a, input logic [WIDTH-1:0] d,
                      input bit chained);
    int n;
    if (!chained) drive_setup(w, a, d);
    push_exp(w, a, d);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    paddr  = {1'b0, $urandom};
    pwdata = $urandom;
    PWRITE = ~PWRITE;
    n = 1;
    while (PREADY !== 1'b1 && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("latency", 64'(n), 64'((sel_z ? 0 : WAITA) + 1));
  endtask

  task automatic release_bus();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic gen(output bit w, output logic [WIDTH:0] a, output logic [WIDTH-1:0] d);
    w = 1'($urandom_range(0, 1));
    a[WIDTH] = 1'($urandom_range(0, 1));
    a[WIDTH-1:0] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 79));
    d = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               w;
    bit               ch;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] d;

    clear_model();
    #1;
    PSEL = 1'b1; PENABLE = 1'b1; PRESETn = 1'b0;
    #1;
    check("reset_pready", 64'(PREADY), 64'(0));
    check("reset_prdata", 64'(prdata), 64'(0));
    check("reset_pslverr", 64'(PSLVERR), 64'(0));
    repeat (3) @(posedge PCLK);
    #2;
    check("reset_hold_pready", 64'(PREADY), 64'(0));
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 33'(i * 4), '0, 1'b0);
      release_bus();
    end

    xfer(1'b1, 33'h1_0000_0008, 32'hDEAD_BEEF, 1'b0); release_bus();
    xfer(1'b0, 33'h0_0000_0008, '0, 1'b0);             release_bus();

    xfer(1'b1, 33'h0_0000_0004, 32'h1111_1111, 1'b0);
    drive_setup(1'b0, 33'h0_0000_0004, '0);
    xfer(1'b0, 33'h0_0000_0004, '0, 1'b1);
    release_bus();

    xfer(1'b1, 33'h0_0000_0000, 32'h0BAD_F00D, 1'b0); release_bus();
    xfer(1'b1, 33'h0_0000_0040, 32'hA5A5_A5A5, 1'b0); release_bus();
    xfer(1'b0, 33'h0_0000_0000, '0, 1'b0);             release_bus();
    xfer(1'b0, 33'h0_0000_0040, '0, 1'b0);             release_bus();
    xfer(1'b0, 33'h0_0000_003C, '0, 1'b0);             release_bus();

    xfer(1'b1, 33'h0_0000_000C, 32'h0000_0C0C, 1'b0); release_bus();
    drive_setup(1'b1, 33'h0_0000_000C, 32'h1234_5678);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (6) @(posedge PCLK);
    #1;
    xfer(1'b0, 33'h0_0000_000C, '0, 1'b0);             release_bus();

    sel_z = 1'b1;
    xfer(1'b1, 33'h0_0000_003C, 32'h0000_FFFF, 1'b0); release_bus();
    xfer(1'b0, 33'h0_0000_003C, '0, 1'b0);             release_bus();
    xfer(1'b1, 33'h0_0000_0020, 32'h5555_AAAA, 1'b0);
    drive_setup(1'b0, 33'h1_0000_0020, '0);
    xfer(1'b0, 33'h1_0000_0020, '0, 1'b1);
    release_bus();
    sel_z = 1'b0;

    ch = 1'b0;
    gen(w, a, d);
    for (int i = 0; i < 300; i++) begin
      xfer(w, a, d, ch);
      gen(w, a, d);
      ch = ($urandom_range(0, 2) == 0) && (i % 50 != 49);
      if (ch) begin
        drive_setup(w, a, d);
      end else begin
        release_bus();
        repeat ($urandom_range(0, 2)) begin
          @(posedge PCLK); #1;
        end
        if (i % 50 == 49) sel_z = ~sel_z;
      end
    end
    sel_z = 1'b0;

    xfer(1'b1, 33'h0_0000_0010, 32'hCAFE_F00D, 1'b0);
    #1;
    PRESETn = 1'b0;
    #1;
    check("midreset_pready", 64'(PREADY), 64'(0));
    check("midreset_prdata", 64'(prdata), 64'(0));
    check("midreset_pslverr", 64'(PSLVERR), 64'(0));
    clear_model();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1'b0, 33'h0_0000_0010, '0, 1'b0); release_bus();
    xfer(1'b0, 33'h0_0000_0008, '0, 1'b0); release_bus();

    repeat (4) @(posedge PCLK);
    check("queue_drained", 64'(expq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
